six_ten_counter: RTL and testbench

Modulo-60 BCD counter: a units digit that counts 0–9 and a tens digit that counts 0–5, giving the sequence 00..59. It is the seconds/minutes stage of the team's clock designs. It free-runs from clock and reset alone, with no enable input. It exposes BCD digits, a binary count, a terminal-count flag for cascading, and seven-segment patterns for both digits.

---
 rtl/six_ten_counter_pkg.sv | 21 ++
 rtl/six_ten_counter_bcd_to_seg.sv | 35 +++
 rtl/six_ten_counter.sv | 71 +++++++
 tb/tb_six_ten_counter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/six_ten_counter_pkg.sv
// Shared constants for the modulo-60 BCD counter: digit limits and
// seven-segment codes in {g,f,e,d,c,b,a} order, active-high.
`timescale 1ns/1ps
package six_ten_counter_pkg;

    localparam logic [3:0] ONES_MAX  = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

endpackage

// File: rtl/six_ten_counter_bcd_to_seg.sv
// BCD digit to seven-segment decoder; codes 10-15 blank. Output is
// inverted when SEG_ACTIVE_LOW is set, for common-anode displays.
`timescale 1ns/1ps
module bcd_to_seg
    import six_ten_counter_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic [3:0] i_bcd,
    output logic [6:0] o_seg
);

    logic [6:0] w_seg;

    // Active-high segment lookup
    always_comb begin
        w_seg = SEG_BLANK;
        case (i_bcd)
            4'd0:    w_seg = SEG_0;
            4'd1:    w_seg = SEG_1;
            4'd2:    w_seg = SEG_2;
            4'd3:    w_seg = SEG_3;
            4'd4:    w_seg = SEG_4;
            4'd5:    w_seg = SEG_5;
            4'd6:    w_seg = SEG_6;
            4'd7:    w_seg = SEG_7;
            4'd8:    w_seg = SEG_8;
            4'd9:    w_seg = SEG_9;
            default: w_seg = SEG_BLANK;
        endcase
    end

    assign o_seg = SEG_ACTIVE_LOW ? ~w_seg : w_seg;

endmodule

// File: rtl/six_ten_counter.sv
// Free-running modulo-60 BCD counter (00..59) with binary count,
// terminal-count flag and seven-segment outputs for both digits.
`timescale 1ns/1ps
module six_ten_counter
    import six_ten_counter_pkg::*;
#(
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [5:0] count,
    output logic       tc,
    output logic [6:0] seg_ones,
    output logic [6:0] seg_tens
);

    logic [3:0] r_ones;
    logic [3:0] r_tens;
    logic [3:0] w_ones_nxt;
    logic [3:0] w_tens_nxt;

    // Next-state: units increment, carry into tens, illegal states recover to 00
    always_comb begin
        w_ones_nxt = 4'd0;
        w_tens_nxt = 4'd0;
        if ((r_ones > ONES_MAX) || (r_tens > TENS_MAX)) begin
            w_ones_nxt = 4'd0;
            w_tens_nxt = 4'd0;
        end else if (r_ones == ONES_MAX) begin
            w_ones_nxt = 4'd0;
            if (r_tens == TENS_MAX) begin
                w_tens_nxt = 4'd0;
            end else begin
                w_tens_nxt = r_tens + 4'd1;
            end
        end else begin
            w_ones_nxt = r_ones + 4'd1;
            w_tens_nxt = r_tens;
        end
    end

    // Digit registers with asynchronous reset to 00
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= 4'd0;
            r_tens <= 4'd0;
        end else begin
            r_ones <= w_ones_nxt;
            r_tens <= w_tens_nxt;
        end
    end

    assign ones  = r_ones;
    assign tens  = r_tens;
    // tens*10 computed as tens*8 + tens*2
    assign count = {r_tens[2:0], 3'b000} + {2'b00, r_tens[2:0], 1'b0} + {2'b00, r_ones};
    assign tc    = (r_tens == TENS_MAX) && (r_ones == ONES_MAX);

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_ones (
        .i_bcd (r_ones),
        .o_seg (seg_ones)
    );

    bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg_tens (
        .i_bcd (r_tens),
        .o_seg (seg_tens)
    );

endmodule

// File: tb/tb_six_ten_counter.sv
// Directed bench for six_ten_counter: a modulo-60 reference model feeds a
// scoreboard queue; two instances cover both segment polarities.
`timescale 1ns/1ps
module tb_six_ten_counter;

    logic       clk;
    logic       rst;
    logic [3:0] ones_a, tens_a, ones_b, tens_b;
    logic [5:0] count_a, count_b;
    logic       tc_a, tc_b;
    logic [6:0] seg_ones_a, seg_tens_a, seg_ones_b, seg_tens_b;

    typedef struct {
        logic [3:0] ones;
        logic [3:0] tens;
        logic [5:0] count;
        logic       tc;
        logic [6:0] seg_ones;
        logic [6:0] seg_tens;
    } exp_t;

    exp_t       sb[$];
    int         n;
    int         vectors;
    int         miscompares;
    logic [6:0] seg_tab [0:9];

    six_ten_counter #(.SEG_ACTIVE_LOW(1'b0)) dut_a (
        .clk      (clk),
        .rst      (rst),
        .ones     (ones_a),
        .tens     (tens_a),
        .count    (count_a),
        .tc       (tc_a),
        .seg_ones (seg_ones_a),
        .seg_tens (seg_tens_a)
    );

    six_ten_counter #(.SEG_ACTIVE_LOW(1'b1)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .ones     (ones_b),
        .tens     (tens_b),
        .count    (count_b),
        .tc       (tc_b),
        .seg_ones (seg_ones_b),
        .seg_tens (seg_tens_b)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h (model state %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic push_expected();
        exp_t e;
        e.ones     = 4'(n % 10);
        e.tens     = 4'(n / 10);
        e.count    = 6'(n);
        e.tc       = (n == 59);
        e.seg_ones = seg_tab[n % 10];
        e.seg_tens = seg_tab[n / 10];
        sb.push_back(e);
    endtask

    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check("ones",       {28'd0, ones_a},     {28'd0, e.ones});
            check("tens",       {28'd0, tens_a},     {28'd0, e.tens});
            check("count",      {26'd0, count_a},    {26'd0, e.count});
            check("tc",         {31'd0, tc_a},       {31'd0, e.tc});
            check("seg_ones",   {25'd0, seg_ones_a}, {25'd0, e.seg_ones});
            check("seg_tens",   {25'd0, seg_tens_a}, {25'd0, e.seg_tens});
            check("count_al",   {26'd0, count_b},    {26'd0, e.count});
            check("seg_ones_al", {25'd0, seg_ones_b}, {25'd0, ~e.seg_ones});
            check("seg_tens_al", {25'd0, seg_tens_b}, {25'd0, ~e.seg_tens});
        end
    endtask

    task automatic step();
        @(posedge clk);
        n = (n + 1) % 60;
        push_expected();
        @(negedge clk);
        compare();
    endtask

    task automatic run_to(input int target);
        for (int k = 0; k < 120 && n != target; k++) begin
            step();
        end
        check("run_to_reached", n, target);
    endtask

    task automatic mid_reset();
        #0.25 rst = 1'b1;
        #0.25;
        n = 0;
        push_expected();
        compare();
        check("tc_after_reset", {31'd0, tc_a}, 32'd0);
        #0.25 rst = 1'b0;
    endtask

    initial begin
        int pulses;
        int last;
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        vectors     = 0;
        miscompares = 0;
        n           = 0;
        rst         = 1'b1;

        // reset state before any edge, then held through the first edge
        #0.5;
        push_expected();
        compare();
        #1.5 rst = 1'b0;
        #0.5;
        push_expected();
        compare();

        // first edge after release gives 01
        step();
        check("first_count", {26'd0, count_a}, 32'd1);

        // units wrap 09 -> 10
        run_to(9);
        step();
        check("wrap_seg_tens", {25'd0, seg_tens_a}, 32'h06);
        check("wrap_count", {26'd0, count_a}, 32'd10);

        // async reset between edges at 37, resume at 01
        run_to(37);
        mid_reset();
        step();
        check("resume_count", {26'd0, count_a}, 32'd1);

        // active-low segment polarity at 08
        run_to(8);
        check("al_seg_tens_08", {25'd0, seg_tens_b}, 32'h40);
        check("al_seg_ones_08", {25'd0, seg_ones_b}, 32'h00);

        // full wrap 59 -> 00
        run_to(59);
        check("tc_at_59", {31'd0, tc_a}, 32'd1);
        check("count_at_59", {26'd0, count_a}, 32'd59);
        step();
        check("tc_after_wrap", {31'd0, tc_a}, 32'd0);
        check("count_after_wrap", {26'd0, count_a}, 32'd0);

        // reset asserted while at 59
        run_to(59);
        mid_reset();

        // 600-cycle period check on tc
        pulses = 0;
        last   = -1;
        for (int i = 0; i < 600; i++) begin
            step();
            if (tc_a === 1'b1) begin
                if (last >= 0) begin
                    check("tc_gap", i - last, 60);
                end
                last = i;
                pulses++;
            end
        end
        check("tc_pulses", pulses, 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
